// File: rtl/sync_pkg.sv
// Shared constants and helpers for the level synchronizer slice.
package sync_pkg;

    // Legal range of flop-chain depth for a synchronizer channel.
    localparam int SYNC_STAGE_MIN = 2;
    localparam int SYNC_STAGE_MAX = 4;

    // Width of the stable-count filter counter; never narrower than 1 bit.
    function automatic int cnt_w(input int filt);
        if (filt < 1) begin
            return 1;
        end
        return $clog2(filt + 1);
    endfunction

endpackage

// File: rtl/sync_level_chan.sv
// One synchronizer channel: flop chain, stable-count glitch filter and
// registered rise/fall pulses that line up with the dout change.
module sync_level_chan
    import sync_pkg::*;
#(
    parameter int   SYNC_STAGE = 2,
    parameter int   FILT_CYC   = 0,
    parameter logic RST_BIT    = 1'b0
) (
    input  logic clk_o,
    input  logic rstn_o,
    input  logic din_i,
    output logic dout_o,
    output logic rise_o,
    output logic fall_o
);

    localparam int CW = cnt_w(FILT_CYC);
    localparam logic [CW-1:0] FILT_MAX = CW'(FILT_CYC);

    // Chain flops are tagged so STA/CDC tools treat them as a synchronizer.
    (* ASYNC_REG = "TRUE" *) logic [SYNC_STAGE-1:0] sync_q;

    logic          sv;
    logic          dout_q, dout_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          rise_q, rise_d;
    logic          fall_q, fall_d;
    logic          upd;

    assign sv = sync_q[SYNC_STAGE-1];

    // Shift the asynchronous level through the synchronizer chain.
    always_ff @(posedge clk_o or negedge rstn_o) begin
        if (!rstn_o) begin
            sync_q <= {SYNC_STAGE{RST_BIT}};
        end else begin
            sync_q <= {sync_q[SYNC_STAGE-2:0], din_i};
        end
    end

    // Filter: dout follows sv only after sv has differed for FILT_CYC+1 edges.
    always_comb begin
        upd    = 1'b0;
        cnt_d  = cnt_q;
        dout_d = dout_q;
        if (sv == dout_q) begin
            cnt_d = '0;
        end else if (cnt_q == FILT_MAX) begin
            upd    = 1'b1;
            dout_d = sv;
            cnt_d  = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
        rise_d = upd & sv;
        fall_d = upd & ~sv;
    end

    // Filter state and edge pulses; pulses share the cycle dout shows the new value.
    always_ff @(posedge clk_o or negedge rstn_o) begin
        if (!rstn_o) begin
            dout_q <= RST_BIT;
            cnt_q  <= '0;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            dout_q <= dout_d;
            cnt_q  <= cnt_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    assign dout_o = dout_q;
    assign rise_o = rise_q;
    assign fall_o = fall_q;

endmodule

// File: rtl/sync_level_filt.sv
// Multi-channel level synchronizer into clk_o. Channels are independent;
// this level only checks parameters and replicates the channel.
module sync_level_filt
    import sync_pkg::*;
#(
    parameter int            CH         = 1,
    parameter int            SYNC_STAGE = 2,
    parameter int            FILT_CYC   = 0,
    parameter logic [CH-1:0] RST_VAL    = {CH{1'b0}}
) (
    input  logic          clk_o,
    input  logic          rstn_o,
    input  logic [CH-1:0] din,
    output logic [CH-1:0] dout,
    output logic [CH-1:0] rise,
    output logic [CH-1:0] fall
);

    // Reject configurations outside the supported range at elaboration.
    if (SYNC_STAGE < SYNC_STAGE_MIN || SYNC_STAGE > SYNC_STAGE_MAX) begin : g_bad_stage
        $error("sync_level_filt: SYNC_STAGE=%0d outside legal range %0d..%0d",
               SYNC_STAGE, SYNC_STAGE_MIN, SYNC_STAGE_MAX);
    end
    if (FILT_CYC < 0) begin : g_bad_filt
        $error("sync_level_filt: FILT_CYC=%0d must be non-negative", FILT_CYC);
    end
    if (CH < 1) begin : g_bad_ch
        $error("sync_level_filt: CH=%0d must be at least 1", CH);
    end

    for (genvar i = 0; i < CH; i++) begin : g_ch
        sync_level_chan #(
            .SYNC_STAGE (SYNC_STAGE),
            .FILT_CYC   (FILT_CYC),
            .RST_BIT    (RST_VAL[i])
        ) u_chan (
            .clk_o  (clk_o),
            .rstn_o (rstn_o),
            .din_i  (din[i]),
            .dout_o (dout[i]),
            .rise_o (rise[i]),
            .fall_o (fall[i])
        );
    end

endmodule

// File: tb/tb_sync_level_filt.sv
// Bench for sync_level_filt: two configurations side by side, a behavioural
// model compared every cycle, and directed literal expectations.
module tb_sync_level_filt;

    logic       clk_o  = 1'b0;
    logic       rstn_o = 1'b0;
    logic [3:0] din_a  = 4'b0000;
    logic [3:0] din_b  = 4'b0000;
    logic [3:0] dout_a, rise_a, fall_a;
    logic [3:0] dout_b, rise_b, fall_b;

    int pass_cnt  = 0;
    int total_cnt = 0;
    int cyc       = 0;

    // Instance a: SYNC_STAGE=2, no filter, RST_VAL=1010.
    sync_level_filt #(
        .CH(4), .SYNC_STAGE(2), .FILT_CYC(0), .RST_VAL(4'b1010)
    ) dut_a (
        .clk_o(clk_o), .rstn_o(rstn_o), .din(din_a),
        .dout(dout_a), .rise(rise_a), .fall(fall_a)
    );

    // Instance b: SYNC_STAGE=3, FILT_CYC=4, RST_VAL=0000.
    sync_level_filt #(
        .CH(4), .SYNC_STAGE(3), .FILT_CYC(4), .RST_VAL(4'b0000)
    ) dut_b (
        .clk_o(clk_o), .rstn_o(rstn_o), .din(din_b),
        .dout(dout_b), .rise(rise_b), .fall(fall_b)
    );

    // Clock generation.
    always #5 clk_o = ~clk_o;

    always @(posedge clk_o) cyc <= cyc + 1;

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        total_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s cyc=%0d actual=%b required=%b", name, cyc, act, exp);
        end
    endtask

    // Behavioural model: sv is din seen SYNC_STAGE samples late; dout adopts
    // sv once sv has disagreed with dout on FILT_CYC+1 consecutive edges.
    function automatic int ss_of(input int u);
        return (u == 0) ? 2 : 3;
    endfunction
    function automatic int filt_of(input int u);
        return (u == 0) ? 0 : 4;
    endfunction
    function automatic logic [3:0] rst_of(input int u);
        return (u == 0) ? 4'b1010 : 4'b0000;
    endfunction

    logic [3:0] m_hist [2][4];
    logic [3:0] m_dout [2];
    logic [3:0] m_rise [2];
    logic [3:0] m_fall [2];
    int         m_run  [2][4];

    initial begin
        forever begin
            @(posedge clk_o or negedge rstn_o);
            for (int u = 0; u < 2; u++) begin
                logic [3:0] rv;
                logic [3:0] dv;
                rv = rst_of(u);
                dv = (u == 0) ? din_a : din_b;
                if (!rstn_o) begin
                    m_dout[u] = rv;
                    m_rise[u] = 4'b0000;
                    m_fall[u] = 4'b0000;
                    for (int c = 0; c < 4; c++) begin
                        m_hist[u][c] = {4{rv[c]}};
                        m_run[u][c]  = 0;
                    end
                end else begin
                    for (int c = 0; c < 4; c++) begin
                        logic sv;
                        sv = m_hist[u][c][ss_of(u)-1];
                        m_rise[u][c] = 1'b0;
                        m_fall[u][c] = 1'b0;
                        if (sv != m_dout[u][c]) begin
                            m_run[u][c]++;
                            if (m_run[u][c] == filt_of(u) + 1) begin
                                m_dout[u][c] = sv;
                                m_rise[u][c] = sv;
                                m_fall[u][c] = ~sv;
                                m_run[u][c]  = 0;
                            end
                        end else begin
                            m_run[u][c] = 0;
                        end
                        m_hist[u][c] = {m_hist[u][c][2:0], dv[c]};
                    end
                end
            end
        end
    end

    // Per-cycle comparison of both instances against the model.
    initial begin
        forever begin
            @(negedge clk_o);
            check("model_dout_a", dout_a, m_dout[0]);
            check("model_rise_a", rise_a, m_rise[0]);
            check("model_fall_a", fall_a, m_fall[0]);
            check("model_dout_b", dout_b, m_dout[1]);
            check("model_rise_b", rise_b, m_rise[1]);
            check("model_fall_b", fall_b, m_fall[1]);
        end
    end

    // Wait n rising edges and land 1 time unit after the last one.
    task automatic edge_wait(input int n);
        repeat (n) @(posedge clk_o);
        #1;
    endtask

    // Directed stimulus with hand-computed expectations.
    initial begin
        // Reset held: din toggles must not reach dout.
        edge_wait(2);
        din_a = 4'b0101;
        edge_wait(2);
        din_a = 4'b1111;
        edge_wait(1);
        check("rst_dout_a", dout_a, 4'b1010);
        check("rst_rise_a", rise_a, 4'b0000);
        check("rst_fall_a", fall_a, 4'b0000);
        check("rst_dout_b", dout_b, 4'b0000);
        din_a = 4'b1010;
        edge_wait(3);
        rstn_o = 1'b1;
        for (int i = 0; i < 20; i++) begin
            edge_wait(1);
            check("rel_nopulse_a", rise_a | fall_a, 4'b0000);
        end
        check("rel_dout_a", dout_a, 4'b1010);

        // Latency SYNC_STAGE=2, FILT_CYC=0: dout/rise after edge n+3.
        din_a = 4'b1011;
        edge_wait(2);
        check("lat_n2_dout_a", dout_a, 4'b1010);
        edge_wait(1);
        check("lat_n3_dout_a", dout_a, 4'b1011);
        check("lat_n3_rise_a", rise_a, 4'b0001);
        edge_wait(1);
        check("lat_n4_rise_a", rise_a, 4'b0000);

        // Simultaneous events across channels.
        din_a = 4'b0000;
        edge_wait(10);
        din_a = 4'b0101;
        edge_wait(3);
        check("sim1_rise_a", rise_a, 4'b0101);
        check("sim1_fall_a", fall_a, 4'b0000);
        edge_wait(10);
        din_a = 4'b1010;
        edge_wait(3);
        check("sim2_rise_a", rise_a, 4'b1010);
        check("sim2_fall_a", fall_a, 4'b0101);
        check("sim2_dout_a", dout_a, 4'b1010);

        // Filter SYNC_STAGE=3, FILT_CYC=4: a 3-cycle pulse is discarded.
        din_b = 4'b0010;
        edge_wait(3);
        din_b = 4'b0000;
        for (int i = 0; i < 15; i++) begin
            edge_wait(1);
            check("glitch_dout_b", dout_b, 4'b0000);
            check("glitch_rise_b", rise_b, 4'b0000);
        end
        // A 10-cycle pulse rises 8 edges after the change, falls 8 after the drop.
        din_b = 4'b0010;
        edge_wait(7);
        check("filt_n7_dout_b", dout_b, 4'b0000);
        edge_wait(1);
        check("filt_n8_dout_b", dout_b, 4'b0010);
        check("filt_n8_rise_b", rise_b, 4'b0010);
        edge_wait(2);
        din_b = 4'b0000;
        edge_wait(7);
        check("filt_f7_dout_b", dout_b, 4'b0010);
        edge_wait(1);
        check("filt_f8_dout_b", dout_b, 4'b0000);
        check("filt_f8_fall_b", fall_b, 4'b0010);

        // Reset while the filter counter is at 2, then full latency again.
        din_b = 4'b0100;
        edge_wait(5);
        rstn_o = 1'b0;
        #1;
        check("midrst_dout_b", dout_b, 4'b0000);
        check("midrst_dout_a", dout_a, 4'b1010);
        check("midrst_pulse_b", rise_b | fall_b, 4'b0000);
        edge_wait(2);
        rstn_o = 1'b1;
        edge_wait(7);
        check("postrst_n7_dout_b", dout_b, 4'b0000);
        check("postrst_nopulse_a", rise_a | fall_a, 4'b0000);
        edge_wait(1);
        check("postrst_n8_dout_b", dout_b, 4'b0100);
        check("postrst_n8_rise_b", rise_b, 4'b0100);
        edge_wait(5);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
